// File: rtl/snoop_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : snoop_req_arbiter_if
// Desc     : Processor request ports and coherence-bus signals of the
//            snoop request arbiter.
// Revision : 1.0
// ============================================================================
interface snoop_req_arbiter_if #(
    parameter int TAGW  = 3,
    parameter int DATAW = 4
);
    logic                    p1_valid, p2_valid, p3_valid;
    logic                    p1_inst,  p2_inst,  p3_inst;
    logic [TAGW-1:0]         p1_tag,   p2_tag,   p3_tag;
    logic [DATAW-1:0]        p1_value, p2_value, p3_value;
    logic                    p1_ready, p2_ready, p3_ready;
    logic                    p1_ack,   p2_ack,   p3_ack;
    logic                    p1_err,   p2_err,   p3_err;
    logic [3+TAGW+DATAW-1:0] bus_word;
    logic                    bus_valid;
    logic                    bus_done;
    logic [2:0]              grant;
    logic                    timeout_err;

    // Arbiter side: issues transactions onto the coherence bus.
    modport master (
        input  p1_valid, p2_valid, p3_valid,
        input  p1_inst,  p2_inst,  p3_inst,
        input  p1_tag,   p2_tag,   p3_tag,
        input  p1_value, p2_value, p3_value,
        input  bus_done,
        output p1_ready, p2_ready, p3_ready,
        output p1_ack,   p2_ack,   p3_ack,
        output p1_err,   p2_err,   p3_err,
        output bus_word, bus_valid, grant, timeout_err
    );

    // Processors and coherence controller.
    modport slave (
        output p1_valid, p2_valid, p3_valid,
        output p1_inst,  p2_inst,  p3_inst,
        output p1_tag,   p2_tag,   p3_tag,
        output p1_value, p2_value, p3_value,
        output bus_done,
        input  p1_ready, p2_ready, p3_ready,
        input  p1_ack,   p2_ack,   p3_ack,
        input  p1_err,   p2_err,   p3_err,
        input  bus_word, bus_valid, grant, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/snoop_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_req_arbiter
// Desc     : Holds one request per processor port, round-robin issues them
//            to the coherence controller, completes on bus_done or timeout.
// Revision : 1.0
// ============================================================================
module snoop_req_arbiter #(
    parameter int TAGW    = 3,
    parameter int DATAW   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                resetn,
    snoop_req_arbiter_if.master bus
);
    localparam int         c_WORDW    = 3 + TAGW + DATAW;
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         w_req_valid;
    logic [2:0]         w_req_inst;
    logic [TAGW-1:0]    w_req_tag [3];
    logic [DATAW-1:0]   w_req_val [3];
    logic [2:0]         w_take;
    logic [2:0]         w_clr;

    logic [2:0]         r_pend;
    logic [2:0]         r_inst;
    logic [TAGW-1:0]    r_tag [3];
    logic [DATAW-1:0]   r_val [3];

    logic [1:0]         r_rr;
    logic [1:0]         w_sel;
    logic [2:0]         w_sel_oh;
    logic [c_WORDW-1:0] w_word;
    logic               w_any;
    logic               w_start;
    logic               w_done;
    logic               w_abort;

    logic [c_WORDW-1:0] r_bus_word;
    logic               r_bus_valid;
    logic [2:0]         r_grant;
    logic [2:0]         r_ack;
    logic [2:0]         r_err;
    logic               r_terr;
    logic [7:0]         r_cnt;

    assign w_req_valid  = {bus.p3_valid, bus.p2_valid, bus.p1_valid};
    assign w_req_inst   = {bus.p3_inst,  bus.p2_inst,  bus.p1_inst};
    assign w_req_tag[0] = bus.p1_tag;
    assign w_req_tag[1] = bus.p2_tag;
    assign w_req_tag[2] = bus.p3_tag;
    assign w_req_val[0] = bus.p1_value;
    assign w_req_val[1] = bus.p2_value;
    assign w_req_val[2] = bus.p3_value;

    // A port is only loaded while empty; pending ports ignore their valid.
    assign w_take = w_req_valid & ~r_pend;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend <= '0;
            r_inst <= '0;
            for (int i = 0; i < 3; i++) begin
                r_tag[i] <= '0;
                r_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_take[i]) begin
                    r_pend[i] <= 1'b1;
                    r_inst[i] <= w_req_inst[i];
                    r_tag[i]  <= w_req_tag[i];
                    r_val[i]  <= w_req_inst[i] ? w_req_val[i] : '0;
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_clr       = '0;
        w_any       = |r_pend;
        w_sel       = 2'd0;

        // First pending port strictly after the last granted one.
        case (r_rr)
            2'd0:    w_sel = r_pend[1] ? 2'd1 : (r_pend[2] ? 2'd2 : 2'd0);
            2'd1:    w_sel = r_pend[2] ? 2'd2 : (r_pend[0] ? 2'd0 : 2'd1);
            default: w_sel = r_pend[0] ? 2'd0 : (r_pend[1] ? 2'd1 : 2'd2);
        endcase

        case (w_sel)
            2'd0:    begin w_sel_oh = 3'b001; w_word = {2'b01, r_inst[0], r_tag[0], r_val[0]}; end
            2'd1:    begin w_sel_oh = 3'b010; w_word = {2'b10, r_inst[1], r_tag[1], r_val[1]}; end
            default: begin w_sel_oh = 3'b100; w_word = {2'b11, r_inst[2], r_tag[2], r_val[2]}; end
        endcase

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // bus_done wins over a timeout landing on the same edge.
                if (bus.bus_done) begin
                    w_done      = 1'b1;
                    w_clr       = r_grant;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_abort     = 1'b1;
                    w_clr       = r_grant;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_start = (r_state == ST_IDLE) && w_any;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rr        <= 2'd2;
            r_cnt       <= '0;
            r_bus_word  <= '0;
            r_bus_valid <= 1'b0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_terr      <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            if (w_start) begin
                r_rr        <= w_sel;
                r_cnt       <= '0;
                r_bus_word  <= w_word;
                r_bus_valid <= 1'b1;
                r_grant     <= w_sel_oh;
            end else if (w_done || w_abort) begin
                r_cnt       <= '0;
                r_bus_word  <= '0;
                r_bus_valid <= 1'b0;
                r_grant     <= '0;
                if (w_done) begin
                    r_ack <= r_grant;
                end else begin
                    r_err  <= r_grant;
                    r_terr <= 1'b1;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign bus.p1_ready    = ~r_pend[0];
    assign bus.p2_ready    = ~r_pend[1];
    assign bus.p3_ready    = ~r_pend[2];
    assign bus.p1_ack      = r_ack[0];
    assign bus.p2_ack      = r_ack[1];
    assign bus.p3_ack      = r_ack[2];
    assign bus.p1_err      = r_err[0];
    assign bus.p2_err      = r_err[1];
    assign bus.p3_err      = r_err[2];
    assign bus.bus_word    = r_bus_word;
    assign bus.bus_valid   = r_bus_valid;
    assign bus.grant       = r_grant;
    assign bus.timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_snoop_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_req_arbiter
// Desc     : Directed stimulus with a queued scoreboard for snoop_req_arbiter.
// Revision : 1.0
// ============================================================================
module tb_snoop_req_arbiter;
    localparam int TAGW    = 3;
    localparam int DATAW   = 4;
    localparam int TIMEOUT = 15;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    snoop_req_arbiter_if #(.TAGW(TAGW), .DATAW(DATAW)) sif();

    snoop_req_arbiter #(.TAGW(TAGW), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (sif)
    );

    typedef struct {
        logic [9:0] word;
        logic [2:0] grant;
        int         dly;   // BUSY cycle carrying bus_done; 0 = never
    } exp_t;

    exp_t exp_q[$];
    int   resp_q[$];
    int   nvec       = 0;
    int   nmis       = 0;
    bit   mon_active = 1'b0;
    bit   exp_terr   = 1'b0;
    logic force_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [2:0] ready_vec();
        return {sif.p3_ready, sif.p2_ready, sif.p1_ready};
    endfunction
    function automatic logic [2:0] ack_vec();
        return {sif.p3_ack, sif.p2_ack, sif.p1_ack};
    endfunction
    function automatic logic [2:0] err_vec();
        return {sif.p3_err, sif.p2_err, sif.p1_err};
    endfunction

    task automatic set_port(input int p, input logic v, input logic inst,
                            input logic [2:0] tag, input logic [3:0] val);
        case (p)
            1: begin sif.p1_valid = v; sif.p1_inst = inst; sif.p1_tag = tag; sif.p1_value = val; end
            2: begin sif.p2_valid = v; sif.p2_inst = inst; sif.p2_tag = tag; sif.p2_value = val; end
            default: begin sif.p3_valid = v; sif.p3_inst = inst; sif.p3_tag = tag; sif.p3_value = val; end
        endcase
    endtask

    task automatic push_exp(input logic [9:0] word, input logic [2:0] grant, input int dly);
        exp_q.push_back('{word: word, grant: grant, dly: dly});
        resp_q.push_back(dly);
    endtask

    // Waits (at a falling edge) for the port to be free, then presents one request.
    task automatic send(input int p, input logic inst, input logic [2:0] tag, input logic [3:0] val);
        logic [2:0] rv;
        int n;
        n  = 0;
        rv = ready_vec();
        while (rv[p-1] !== 1'b1 && n < 300) begin
            @(negedge clock);
            rv = ready_vec();
            n++;
        end
        if (rv[p-1] !== 1'b1) begin
            nvec++;
            nmis++;
            $display("FAIL send_wait p%0d: ready=%b after %0d cycles, expected 1", p, rv[p-1], n);
            return;
        end
        set_port(p, 1'b1, inst, tag, val);
        @(posedge clock);
        @(negedge clock);
        set_port(p, 1'b0, 1'b0, 3'd0, 4'd0);
        rv = ready_vec();
        check($sformatf("ready_drop_p%0d", p), rv[p-1], 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sif.bus_valid || mon_active) && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            nvec++;
            nmis++;
            $display("FAIL wait_idle: %0d transactions outstanding, expected 0", exp_q.size());
            exp_q.delete();
            resp_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    // Coherence-controller model: raises bus_done in the requested BUSY cycle.
    initial begin : responder
        bit act;
        int cnt;
        int d;
        act = 1'b0;
        cnt = 0;
        d   = 0;
        sif.bus_done = 1'b0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                act = 1'b0;
                sif.bus_done = 1'b0;
            end else if (sif.bus_valid) begin
                if (!act) begin
                    act = 1'b1;
                    cnt = 1;
                    d   = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
                end else begin
                    cnt++;
                end
                sif.bus_done = (d != 0 && cnt == d);
            end else begin
                act = 1'b0;
                sif.bus_done = force_done;
            end
        end
    end

    initial begin : monitor
        exp_t cur;
        bit   pulse_chk;
        bit   stable_ok;
        bit   ab;
        int   len;
        int   elen;
        pulse_chk = 1'b0;
        stable_ok = 1'b1;
        len       = 0;
        cur       = '{word: '0, grant: '0, dly: 0};
        forever begin
            @(negedge clock);
            if (!resetn) begin
                mon_active = 1'b0;
                pulse_chk  = 1'b0;
                exp_terr   = 1'b0;
                continue;
            end
            if (pulse_chk) begin
                check("ack_one_cycle", ack_vec(), 3'b000);
                check("err_one_cycle", err_vec(), 3'b000);
                pulse_chk = 1'b0;
            end
            if (sif.bus_valid) begin
                if (!mon_active) begin
                    mon_active = 1'b1;
                    len        = 1;
                    stable_ok  = 1'b1;
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL unexpected_txn: word=%b grant=%b, expected none",
                                 sif.bus_word, sif.grant);
                        cur = '{word: '0, grant: '0, dly: 0};
                    end else begin
                        cur = exp_q.pop_front();
                        check("bus_word", sif.bus_word, cur.word);
                        check("grant", sif.grant, cur.grant);
                    end
                end else begin
                    len++;
                    if (sif.bus_word !== cur.word || sif.grant !== cur.grant) stable_ok = 1'b0;
                end
            end else if (mon_active) begin
                mon_active = 1'b0;
                ab   = !(cur.dly > 0 && cur.dly <= TIMEOUT);
                elen = ab ? TIMEOUT : cur.dly;
                if (ab) exp_terr = 1'b1;
                check("hold_stable", stable_ok, 1'b1);
                check("valid_cycles", len, elen);
                check("grant_idle", sif.grant, 3'b000);
                check("ack", ack_vec(), ab ? 3'b000 : cur.grant);
                check("err", err_vec(), ab ? cur.grant : 3'b000);
                check("timeout_err", sif.timeout_err, exp_terr);
                check("ready_back", ready_vec() & cur.grant, cur.grant);
                pulse_chk = 1'b1;
            end
        end
    end

    initial begin : stim
        int n;
        for (int p = 1; p <= 3; p++) set_port(p, 1'b0, 1'b0, 3'd0, 4'd0);

        #1 resetn = 1'b0;
        #1;
        check("rst_ready", ready_vec(), 3'b111);
        check("rst_valid", sif.bus_valid, 1'b0);
        check("rst_grant", sif.grant, 3'b000);
        check("rst_word", sif.bus_word, 10'd0);
        check("rst_terr", sif.timeout_err, 1'b0);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);

        // Single read on P2, done in the 3rd BUSY cycle.
        push_exp(10'b10_0_101_0000, 3'b010, 3);
        send(2, 1'b0, 3'd5, 4'd9);
        wait_idle();

        // Single write on P3, done in the first BUSY cycle.
        push_exp(10'b11_1_010_1010, 3'b100, 1);
        send(3, 1'b1, 3'd2, 4'hA);
        wait_idle();

        // bus_done while idle must not complete anything.
        force_done = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("idle_done_valid", sif.bus_valid, 1'b0);
            check("idle_done_ack", ack_vec(), 3'b000);
        end
        force_done = 1'b0;
        @(negedge clock);

        // Round-robin: all ports request together and re-request immediately.
        push_exp(10'b01_0_001_0000, 3'b001, 1);
        push_exp(10'b10_1_011_0101, 3'b010, 1);
        push_exp(10'b11_0_111_0000, 3'b100, 1);
        push_exp(10'b01_0_001_0000, 3'b001, 1);
        push_exp(10'b10_1_011_0101, 3'b010, 1);
        push_exp(10'b11_0_111_0000, 3'b100, 1);
        fork
            begin send(1, 1'b0, 3'd1, 4'd0); send(1, 1'b0, 3'd1, 4'd0); end
            begin send(2, 1'b1, 3'd3, 4'd5); send(2, 1'b1, 3'd3, 4'd5); end
            begin send(3, 1'b0, 3'd7, 4'hF); send(3, 1'b0, 3'd7, 4'hF); end
        join
        wait_idle();

        // bus_done on the same edge the timeout would fire: completion wins.
        push_exp(10'b01_1_000_1111, 3'b001, TIMEOUT);
        send(1, 1'b1, 3'd0, 4'hF);
        wait_idle();

        // Timeout abort, then a normal P2 transaction with timeout_err still set.
        push_exp(10'b01_1_100_0011, 3'b001, 0);
        send(1, 1'b1, 3'd4, 4'd3);
        wait_idle();
        check("terr_sticky", sif.timeout_err, 1'b1);
        push_exp(10'b10_0_110_0000, 3'b010, 2);
        send(2, 1'b0, 3'd6, 4'd2);
        wait_idle();

        // Asynchronous reset in the middle of a transaction.
        push_exp(10'b01_1_101_0101, 3'b001, 0);
        send(1, 1'b1, 3'd5, 4'd5);
        n = 0;
        while (!sif.bus_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("pre_rst_valid", sif.bus_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_valid", sif.bus_valid, 1'b0);
        check("mid_rst_grant", sif.grant, 3'b000);
        check("mid_rst_ready", ready_vec(), 3'b111);
        check("mid_rst_terr", sif.timeout_err, 1'b0);
        check("mid_rst_ack", ack_vec() | err_vec(), 3'b000);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);

        // After reset P1 has first priority again over P3.
        push_exp(10'b01_0_010_0000, 3'b001, 2);
        push_exp(10'b11_0_001_0000, 3'b100, 2);
        fork
            send(1, 1'b0, 3'd2, 4'd7);
            send(3, 1'b0, 3'd1, 4'hC);
        join
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/snoop_req_arbiter.md
Name: snoop_req_arbiter

Overview:
- Upstream request stage for the MSI-style snooping coherence controller.
- Collects read/write requests from three processor ports (P1..P3) and holds one request per port.
- Round-robin arbitrates between pending ports and drives one packed bus transaction at a time to the coherence controller.
- Holds each transaction until the controller acknowledges it or a timeout fires.

Parameters:
- TAGW, 3, tag field width.
- DATAW, 4, data/value field width.
- TIMEOUT, 15, maximum cycles bus_valid is held without bus_done (range 2..255).

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pN_valid  in  1  (N=1,2,3) request present on port N.
- pN_inst  in  1  0=read, 1=write.
- pN_tag  in  TAGW  block tag.
- pN_value  in  DATAW  write data; ignored for reads.
- pN_ready  out  1  port N holding register empty.
- pN_ack  out  1  one-cycle pulse: port N transaction completed.
- pN_err  out  1  one-cycle pulse: port N transaction aborted by timeout.
- bus_word  out  3+TAGW+DATAW  packed transaction: [top:top-1] processor id (1..3), [TAGW+DATAW] inst, next TAGW bits tag, low DATAW bits value.
- bus_valid  out  1  bus_word valid; held until completion or abort.
- bus_done  in  1  controller has consumed the transaction.
- grant  out  3  one-hot owner of the current transaction (bit0=P1); 0 when idle.
- timeout_err  out  1  sticky; set on any abort, cleared only by reset.

Behaviour:
- Reset (async, resetn=0): all holding registers empty, pN_ready=1, pN_ack=pN_err=0, bus_valid=0, bus_word=0, grant=0, timeout_err=0, state=IDLE, rr pointer=P3 (so P1 has first priority), timeout counter=0. Outputs go to these values immediately on resetn falling, not at the next edge.
- Capture: at an edge with pN_valid && pN_ready, port N stores inst, tag, and value. For reads, value is stored as 0. pN_ready drops after that edge.
- While pending, pN_ready=0 and pN_valid is ignored.
- FSM states: IDLE, BUSY.
- IDLE: at an edge with any pending port, grant the first pending port after the rr pointer (order P1->P2->P3->P1).
  - On that grant: load bus_word, set bus_valid=1 and the grant bit, set rr pointer to the granted port, clear the counter, and go to BUSY.
  - A port captured at edge E is eligible at edge E+1 at the earliest, so bus_valid rises at least one cycle after capture.
- BUSY: bus_word and grant are stable.
  - If bus_done=1 at an edge: bus_valid=0, grant=0, clear the owner's holding register, pulse pN_ack for one cycle, go to IDLE.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 at an edge without bus_done: abort. Abort clears bus_valid and grant, clears the owner's holding register, pulses pN_err, sets timeout_err, and goes to IDLE. bus_valid is therefore high for exactly TIMEOUT cycles on abort.
  - bus_done on the same edge the timeout would fire: treat as completion (ack, no err).
- IDLE always lasts at least one cycle, so bus_valid is low for at least one cycle between transactions.
- bus_done while IDLE is ignored.
- The owner's pN_ready returns to 1 in the cycle after completion or abort. A new request on that port may be captured at the following edge.
- Requests on non-owner ports are captured normally while BUSY.
- Processor id on bus_word: P1=2'b01, P2=2'b10, P3=2'b11. The value 00 is never driven while bus_valid=1.
- Reset mid-transaction: the transaction is dropped with no ack/err pulse. After resetn rises, the first edge behaves as from reset.

Test Plan:
- Reset: resetn=0 mid-BUSY -> bus_valid=0, grant=0, p1..p3_ready=1, timeout_err=0 with no clock edge required.
- Single read: p2 inst=0 tag=5 value=9 captured; bus_done at 3rd BUSY cycle -> bus_word=10'b10_0_101_0000, grant=3'b010, p2_ack pulse once, p2_ready=1 the next cycle.
- Single write: p3 inst=1 tag=2 value=0xA -> bus_word=10'b11_1_010_1010; bus_done at first BUSY cycle -> p3_ack, bus_valid low for at least 1 cycle.
- Round-robin: all three ports request at the same edge; bus_done returned after 1 cycle each, with all ports re-requesting immediately -> grant order 001,010,100,001,010,100.
- Timeout: P1 write, bus_done never asserted -> bus_valid high exactly 15 cycles, p1_err pulse, timeout_err=1 sticky, p1_ack=0; next P2 request is still served normally.
- Done/timeout collision: bus_done=1 on the 15th BUSY cycle -> p1_ack pulse, no p1_err, timeout_err stays 0.
